// File: rtl/universal_shift_sequencer_pkg.sv
// ============================================================================
// Module   : usr_pkg
// Brief    : Shared op codes and FSM state encoding for the universal shift
//            sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package usr_pkg;

    // Command op codes; 3'b111 is reserved and treated as HOLD
    localparam logic [2:0] USR_OP_HOLD = 3'b000;
    localparam logic [2:0] USR_OP_SHR  = 3'b001;
    localparam logic [2:0] USR_OP_SHL  = 3'b010;
    localparam logic [2:0] USR_OP_LOAD = 3'b011;
    localparam logic [2:0] USR_OP_ASR  = 3'b100;
    localparam logic [2:0] USR_OP_ROR  = 3'b101;
    localparam logic [2:0] USR_OP_ROL  = 3'b110;

    // Sequencer states
    typedef enum logic [0:0] {
        USR_IDLE = 1'b0,
        USR_RUN  = 1'b1
    } usr_state_t;

endpackage

`default_nettype wire

// File: rtl/universal_shift_sequencer_if.sv
// ============================================================================
// Module   : universal_shift_sequencer_if
// Brief    : Command handshake, parallel data and serial fill/out signals of
//            the universal shift sequencer. The controller side uses the
//            master modport, the sequencer the slave modport.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface universal_shift_sequencer_if #(
    parameter int WIDTH = 8
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [CNT_W-1:0] cmd_amt;
    logic [WIDTH-1:0] data_in;
    logic             shift_in_left;
    logic             shift_in_right;
    logic [WIDTH-1:0] data_out;
    logic             serial_out;
    logic             busy;
    logic             done;

    modport master (
        output cmd_valid, cmd_op, cmd_amt, data_in, shift_in_left, shift_in_right,
        input  cmd_ready, data_out, serial_out, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_amt, data_in, shift_in_left, shift_in_right,
        output cmd_ready, data_out, serial_out, busy, done
    );

endinterface

`default_nettype wire

// File: rtl/universal_shift_sequencer_step.sv
// ============================================================================
// Module   : usr_step
// Brief    : Combinational single-bit step of the universal shift register.
//            Produces the next register value, the bit leaving the register
//            and a flag telling whether the op actually shifts.
//            Rotates exist only when USR_ROTATE_EN is defined; otherwise the
//            rotate op codes fall into the no-shift default.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module usr_step
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  wire logic [2:0]       i_op,
    input  wire logic [WIDTH-1:0] i_value,
    input  wire logic             i_fill_l,
    input  wire logic             i_fill_r,
    output logic      [WIDTH-1:0] o_value,
    output logic                  o_out_bit,
    output logic                  o_is_shift
);

    // One step of the selected op; non-shifting ops pass the value through
    always_comb begin
        o_value    = i_value;
        o_out_bit  = 1'b0;
        o_is_shift = 1'b0;
        case (i_op)
            USR_OP_SHR: begin
                o_value    = {i_fill_r, i_value[WIDTH-1:1]};
                o_out_bit  = i_value[0];
                o_is_shift = 1'b1;
            end
            USR_OP_SHL: begin
                o_value    = {i_value[WIDTH-2:0], i_fill_l};
                o_out_bit  = i_value[WIDTH-1];
                o_is_shift = 1'b1;
            end
            USR_OP_ASR: begin
                o_value    = {i_value[WIDTH-1], i_value[WIDTH-1:1]};
                o_out_bit  = i_value[0];
                o_is_shift = 1'b1;
            end
`ifdef USR_ROTATE_EN
            USR_OP_ROR: begin
                o_value    = {i_value[0], i_value[WIDTH-1:1]};
                o_out_bit  = i_value[0];
                o_is_shift = 1'b1;
            end
            USR_OP_ROL: begin
                o_value    = {i_value[WIDTH-2:0], i_value[WIDTH-1]};
                o_out_bit  = i_value[WIDTH-1];
                o_is_shift = 1'b1;
            end
`endif
            default: begin
                o_value    = i_value;
                o_out_bit  = 1'b0;
                o_is_shift = 1'b0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/universal_shift_sequencer.sv
// ============================================================================
// Module   : universal_shift_sequencer
// Brief    : Multi-step universal shift register. An accepted command (load,
//            hold, shift or rotate by N) executes one bit per clock; the
//            accept edge performs the first step. done pulses for one cycle
//            with cmd_ready already high so commands can run back to back.
//            Optional macro: USR_ROTATE_EN enables ROR/ROL.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module universal_shift_sequencer
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    universal_shift_sequencer_if.slave  bus
);

    localparam int               CNT_W     = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] c_MAX_AMT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);

    usr_state_t       r_state;
    logic [2:0]       r_op;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_data;
    logic             r_serial;
    logic             r_done;

    logic [2:0]       w_step_op;
    logic [WIDTH-1:0] w_step_value;
    logic             w_step_out;
    logic             w_step_is_shift;
    logic [CNT_W-1:0] w_amt;

    // The single step unit sees the live command in IDLE and the latched op in RUN
    assign w_step_op = (r_state == USR_RUN) ? r_op : bus.cmd_op;

    // Amounts beyond the register width saturate to a full-width shift
    assign w_amt = (bus.cmd_amt > c_MAX_AMT) ? c_MAX_AMT : bus.cmd_amt;

    usr_step #(
        .WIDTH      (WIDTH)
    ) u_step (
        .i_op       (w_step_op),
        .i_value    (r_data),
        .i_fill_l   (bus.shift_in_left),
        .i_fill_r   (bus.shift_in_right),
        .o_value    (w_step_value),
        .o_out_bit  (w_step_out),
        .o_is_shift (w_step_is_shift)
    );

    // Command FSM: accept and first step in IDLE, remaining steps in RUN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= USR_IDLE;
            r_op     <= USR_OP_HOLD;
            r_cnt    <= '0;
            r_data   <= '0;
            r_serial <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                USR_IDLE: begin
                    if (bus.cmd_valid) begin
                        if (bus.cmd_op == USR_OP_LOAD) begin
                            r_data <= bus.data_in;
                            r_done <= 1'b1;
                        end else if (w_step_is_shift && (w_amt != '0)) begin
                            r_data   <= w_step_value;
                            r_serial <= w_step_out;
                            if (w_amt == c_ONE) begin
                                r_done <= 1'b1;
                            end else begin
                                r_op    <= bus.cmd_op;
                                r_cnt   <= w_amt - c_ONE;
                                r_state <= USR_RUN;
                            end
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                USR_RUN: begin
                    r_data   <= w_step_value;
                    r_serial <= w_step_out;
                    r_cnt    <= r_cnt - c_ONE;
                    if (r_cnt == c_ONE) begin
                        r_done  <= 1'b1;
                        r_state <= USR_IDLE;
                    end
                end
                default: begin
                    r_state <= USR_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready  = (r_state == USR_IDLE);
    assign bus.busy       = (r_state != USR_IDLE);
    assign bus.data_out   = r_data;
    assign bus.serial_out = r_serial;
    assign bus.done       = r_done;

endmodule

`default_nettype wire

// File: tb/tb_universal_shift_sequencer.sv
// ============================================================================
// Module   : tb_universal_shift_sequencer
// Brief    : Scoreboard bench for universal_shift_sequencer (WIDTH=8).
//            Directed commands push their expected result and done cycle;
//            a monitor pops and compares on every done pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_universal_shift_sequencer;

    localparam int WIDTH = 8;

    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_SHR  = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_LOAD = 3'b011;
    localparam logic [2:0] OP_ASR  = 3'b100;
    localparam logic [2:0] OP_ROL  = 3'b110;
    localparam logic [2:0] OP_RSV  = 3'b111;

    typedef struct packed {
        logic [7:0] data;
        logic       ser;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t m_e;
    logic exp_ser;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    universal_shift_sequencer_if #(.WIDTH(WIDTH)) bus ();

    universal_shift_sequencer #(
        .WIDTH (WIDTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected done=0 (cycle %0d)", cyc);
            end else begin
                m_e = sb.pop_front();
                chk("done_data", {24'd0, bus.data_out}, {24'd0, m_e.data});
                chk("done_serial", {31'd0, bus.serial_out}, {31'd0, m_e.ser});
                chk("done_cycle", cyc, m_e.cyc);
                chk("done_ready", {31'd0, bus.cmd_ready}, 32'd1);
                chk("done_busy", {31'd0, bus.busy}, 32'd0);
            end
        end
    end

    // Offer a command, hold it until accepted, then record the expectation
    task automatic issue(input logic [2:0] op, input logic [3:0] amt, input logic [7:0] din,
                         input logic fl, input logic fr, input bit push,
                         input logic [7:0] xd, input logic xs, input int lat);
        bit   acc = 1'b0;
        logic rdy;
        exp_t e;
        @(negedge clk);
        bus.cmd_valid      = 1'b1;
        bus.cmd_op         = op;
        bus.cmd_amt        = amt;
        bus.data_in        = din;
        bus.shift_in_left  = fl;
        bus.shift_in_right = fr;
        for (int i = 0; i < 100; i++) begin
            rdy = bus.cmd_ready;
            @(posedge clk);
            #1;
            if (rdy === 1'b1) begin
                acc = 1'b1;
                break;
            end
        end
        bus.cmd_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got ready=0 expected ready=1 within 100 cycles");
        end else if (push) begin
            e.data = xd;
            e.ser  = xs;
            e.cyc  = cyc + lat - 1;
            sb.push_back(e);
        end
    endtask

    // Bounded wait for all outstanding expectations to be consumed
    task automatic wait_drain();
        for (int i = 0; i < 200; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        chk("drain_pending", sb.size(), 32'd0);
    endtask

    initial begin
        bus.cmd_valid      = 1'b0;
        bus.cmd_op         = OP_HOLD;
        bus.cmd_amt        = '0;
        bus.data_in        = '0;
        bus.shift_in_left  = 1'b0;
        bus.shift_in_right = 1'b0;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_data", {24'd0, bus.data_out}, 32'h00);
        chk("rst_ready", {31'd0, bus.cmd_ready}, 32'd1);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_serial", {31'd0, bus.serial_out}, 32'd0);

        // LOAD then SHR by 3 with fill 1
        issue(OP_LOAD, 4'd0, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1);
        issue(OP_SHR, 4'd3, 8'h00, 1'b0, 1'b1, 1'b1, 8'hF4, 1'b1, 3);
        @(negedge clk);
        chk("shr_busy_mid", {31'd0, bus.busy}, 32'd1);
        wait_drain();

        // ASR keeps the sign bit
        issue(OP_LOAD, 4'd0, 8'h81, 1'b0, 1'b0, 1'b1, 8'h81, 1'b1, 1);
        issue(OP_ASR, 4'd2, 8'h00, 1'b0, 1'b0, 1'b1, 8'hE0, 1'b0, 2);

        // ROL by 4 (HOLD-like without the rotate feature)
        issue(OP_LOAD, 4'd0, 8'h3C, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1);
`ifdef USR_ROTATE_EN
        issue(OP_ROL, 4'd4, 8'h00, 1'b0, 1'b0, 1'b1, 8'hC3, 1'b1, 4);
        exp_ser = 1'b1;
`else
        issue(OP_ROL, 4'd4, 8'h00, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1);
        exp_ser = 1'b0;
`endif

        // Saturated SHL with a second command held during busy
        issue(OP_LOAD, 4'd0, 8'hFF, 1'b0, 1'b0, 1'b1, 8'hFF, exp_ser, 1);
        issue(OP_SHL, 4'd12, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 8);
        issue(OP_LOAD, 4'd0, 8'h77, 1'b0, 1'b0, 1'b1, 8'h77, 1'b1, 1);

        // No-data-change commands: HOLD, amount 0, reserved op
        issue(OP_HOLD, 4'd5, 8'h00, 1'b1, 1'b1, 1'b1, 8'h77, 1'b1, 1);
        issue(OP_SHR, 4'd0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h77, 1'b1, 1);
        issue(OP_RSV, 4'd3, 8'h00, 1'b1, 1'b1, 1'b1, 8'h77, 1'b1, 1);
        wait_drain();

        // Reset in the middle of a 6-step SHR: no done, immediate clear
        issue(OP_SHR, 4'd6, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_data", {24'd0, bus.data_out}, 32'h00);
        chk("midrst_serial", {31'd0, bus.serial_out}, 32'd0);
        chk("midrst_ready", {31'd0, bus.cmd_ready}, 32'd1);
        chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
        chk("midrst_done", {31'd0, bus.done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        issue(OP_LOAD, 4'd0, 8'h5A, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 1);

        // Single-step SHL, then SHR whose fill changes between steps
        issue(OP_SHL, 4'd1, 8'h00, 1'b1, 1'b0, 1'b1, 8'hB5, 1'b0, 1);
        issue(OP_SHR, 4'd2, 8'h00, 1'b0, 1'b1, 1'b1, 8'h6D, 1'b0, 2);
        bus.shift_in_right = 1'b0;
        wait_drain();
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/universal_shift_sequencer.md
# universal_shift_sequencer

Parametrised multi-step universal shift register with a command handshake. One accepted command (load, hold, logical/arithmetic shift or rotate by N bits) is executed one bit per clock. Serial fill bits are sampled live on every step. It replaces the fixed 8-bit single-step shift register in serial-link and bit-serial datapaths, where a controller issues shift bursts and waits for completion.

## Interface
- WIDTH, 8, register width in bits (≥2).
- CNT_W, $clog2(WIDTH+1), localparam; width of `cmd_amt` and the step counter.

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  block can accept a command; high only in IDLE
- cmd_op  in  3  operation code (see Operation)
- cmd_amt  in  CNT_W  bit count for shift/rotate ops
- data_in  in  WIDTH  parallel load value, sampled at accept
- shift_in_left  in  1  fill bit for SHL, sampled every step
- shift_in_right  in  1  fill bit for SHR, sampled every step
- data_out  out  WIDTH  register contents
- serial_out  out  1  last bit shifted or rotated out
- busy  out  1  equals !cmd_ready
- done  out  1  one-cycle completion pulse

## Operation
- Op codes:
  - 000 HOLD
  - 001 SHR (logical right, fill `shift_in_right` at MSB)
  - 010 SHL (left, fill `shift_in_left` at LSB)
  - 011 LOAD
  - 100 ASR (right, fill with current MSB)
  - 101 ROR
  - 110 ROL
  - 111 reserved, behaves as HOLD
- Accept occurs on a rising edge when `cmd_valid && cmd_ready`. `cmd_valid` while busy is ignored; the command is not queued.
- FSM states: IDLE and RUN.
- At the accept edge:
  - LOAD: `data_out <= data_in`; `done <= 1`; stay IDLE.
  - HOLD, reserved op, or `cmd_amt==0`: register unchanged; `done <= 1`; stay IDLE.
  - Shift/rotate with amt ≥ 1: perform the first step. If amt==1, set `done <= 1` and stay IDLE. Otherwise latch op, set `cnt <= amt-1`, and go to RUN.
- RUN: one step per edge, `cnt` decrements. On the step where `cnt==1`, set `done <= 1` and return to IDLE.
- `cmd_amt > WIDTH` saturates to WIDTH.
- `serial_out` updates on every step with the bit leaving the register: bit 0 for right ops, bit WIDTH-1 for left ops. It holds its value on LOAD and HOLD.
- `done` is high for exactly one cycle per accepted command. In that cycle `cmd_ready` is already high, so back-to-back commands lose no cycles.

## Timing
- Reset values: `data_out=0`, `serial_out=0`, `done=0`, `cmd_ready=1`, `busy=0`, state IDLE, `cnt=0`.
- Reset asserted mid-RUN clears all state immediately (asynchronously). The command in progress is discarded and no `done` pulse is produced.
- Shift by N (1..WIDTH): N edges, the first being the accept edge. `done` is high in the cycle after edge N.
- LOAD, HOLD, or amt 0: `done` is high in the cycle after the accept edge.
- Fill bits and the ASR sign bit are taken from the values present at each step edge, not latched at accept.

## Configuration
- `USR_ROTATE_EN` defined: ROR and ROL execute as specified.
- Not defined: op codes 101 and 110 behave as HOLD (single-cycle `done`, no data change), and the rotate logic is not synthesised.

## Structure
- Package `usr_pkg` holds:
  - op code localparams `USR_OP_HOLD` through `USR_OP_ROL`
  - state encoding `USR_IDLE` and `USR_RUN`
- Sub-module `usr_step` is combinational. It takes (WIDTH, op, value, fill_l, fill_r) and returns the next value plus the out bit. It is instantiated once and shared by the accept-edge and RUN paths.
- The FSM, counter and registers live in `universal_shift_sequencer`.

## Test plan
All cases use WIDTH=8.
- Reset, no commands: `data_out=0x00`, `cmd_ready=1`, `busy=0`, `done=0`, `serial_out=0`.
- LOAD 0xA5, then SHR amt=3 with `shift_in_right=1`: `data_out=0xF4` after the 3rd edge, `done` in the following cycle, `serial_out=1`, `busy` high for 2 cycles.
- LOAD 0x81, then ASR amt=2: `data_out=0xE0`, `serial_out=0`.
- LOAD 0x3C, then ROL amt=4:
  - with `USR_ROTATE_EN`: `data_out=0xC3`, `serial_out=1`.
  - without it: `data_out=0x3C`, `done` one cycle after accept.
- LOAD 0xFF, then SHL amt=12 with `shift_in_left=0`: saturates to 8 steps, giving `data_out=0x00` and `done` after edge 8. A second command held on `cmd_valid` during busy is accepted only in the `done` cycle.
- SHR amt=6 with `rst` pulsed after 2 steps: outputs return to reset values at once and no `done` is produced. LOAD 0x5A after release gives `data_out=0x5A`.
